// File: rtl/bcd_split_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with start/busy/done handshake and overflow saturation.
// Leading-zero blanking is built only when BCD_SPLIT_SEQ_BLANK_EN is defined; otherwise blank is tied low.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | one shift-add-3 iteration per cycle, cnt_q iterations left
// S_DONE  | result registered, done pulse; start accepted for back-to-back
module bcd_split_seq #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    bin_q, bin_nx;
   logic [4*DIGITS-1:0] dig_q, dig_adj, dig_nx, bcd_nx;
   logic [CW-1:0]       cnt_q;
   logic                ovf_q, carry, ovf_nx;
   logic                accept, last;

   assign accept = start && (state_q != S_SHIFT);
   assign last   = (state_q == S_SHIFT) && (cnt_q == CW'(1));
   assign busy   = (state_q == S_SHIFT);
   assign done   = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = start ? S_SHIFT : S_IDLE;
         S_SHIFT:        state_d = (cnt_q == CW'(1)) ? S_DONE : S_SHIFT;
         default:        state_d = S_IDLE;
      endcase
   end

   // Digits are adjusted independently; a 1 leaving the top digit means the value no longer fits.
   always_comb begin
      dig_adj = dig_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_q[4*i +: 4] >= 4'd5)
            dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
      {carry, dig_nx, bin_nx} = {dig_adj, bin_q, 1'b0};
      ovf_nx = ovf_q | carry;
      bcd_nx = ovf_nx ? {DIGITS{4'h9}} : dig_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         bin_q    <= '0;
         dig_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            bin_q <= bin;
            dig_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CW'(WIDTH);
         end else if (state_q == S_SHIFT) begin
            bin_q <= bin_nx;
            dig_q <= dig_nx;
            ovf_q <= ovf_nx;
            cnt_q <= cnt_q - CW'(1);
            if (last) begin
               bcd      <= bcd_nx;
               overflow <= ovf_nx;
            end
         end
      end
   end

`ifdef BCD_SPLIT_SEQ_BLANK_EN
   logic [DIGITS-1:0] blank_nx;
   logic              hi_zero;

   // Digit 0 is never blanked so that zero still shows a single "0".
   always_comb begin
      blank_nx = '0;
      hi_zero  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         hi_zero     = hi_zero & (bcd_nx[4*i +: 4] == 4'd0);
         blank_nx[i] = hi_zero & ~ovf_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         blank <= '0;
      else if (last)
         blank <= blank_nx;
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_split_seq.sv
// Directed bench for bcd_split_seq: a 6-bit/2-digit instance and a 10-bit/3-digit instance.
module tb_bcd_split_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start3;
   logic [5:0]  bin;
   logic [9:0]  bin3;
   logic        busy, done, overflow;
   logic [7:0]  bcd;
   logic [1:0]  blank;
   logic        busy3, done3, overflow3;
   logic [11:0] bcd3;
   logic [2:0]  blank3;

   int vectors     = 0;
   int miscompares = 0;

`ifdef BCD_SPLIT_SEQ_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   bcd_split_seq #(.WIDTH(6), .DIGITS(2)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .blank(blank)
   );

   bcd_split_seq #(.WIDTH(10), .DIGITS(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin(bin3),
      .busy(busy3), .done(done3), .bcd(bcd3), .overflow(overflow3), .blank(blank3)
   );

   task automatic do_conv(input logic [5:0] v, output int nbusy, output bit got);
      @(negedge clk); start = 1'b1; bin = v;
      @(negedge clk); start = 1'b0;
      nbusy = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (done) got = 1'b1;
         else begin
            if (busy) nbusy++;
            @(negedge clk);
         end
      end
   endtask

   task automatic do_conv3(input logic [9:0] v, output int nbusy, output bit got);
      @(negedge clk); start3 = 1'b1; bin3 = v;
      @(negedge clk); start3 = 1'b0;
      nbusy = 0; got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (done3) got = 1'b1;
         else begin
            if (busy3) nbusy++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start3 = 1'b0; bin = '0; bin3 = '0;
      repeat (3) @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL reset_bcd got %h want 00", bcd); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow); end
      vectors++; if (blank !== 2'b00) begin miscompares++; $display("FAIL reset_blank got %b want 00", blank); end
      vectors++; if (bcd3 !== 12'h000) begin miscompares++; $display("FAIL reset_bcd3 got %h want 000", bcd3); end
      rst = 1'b0;
   endtask

   task automatic test_max63();
      int nb; bit got;
      do_conv(6'd63, nb, got);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL max63_done got %b want 1", got); end
      vectors++; if (nb !== 6) begin miscompares++; $display("FAIL max63_busy_cycles got %0d want 6", nb); end
      vectors++; if (bcd !== 8'h63) begin miscompares++; $display("FAIL max63_bcd got %h want 63", bcd); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL max63_ovf got %b want 0", overflow); end
      vectors++; if (blank !== 2'b00) begin miscompares++; $display("FAIL max63_blank got %b want 00", blank); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL max63_done_width got %b want 0", done); end
      vectors++; if (bcd !== 8'h63) begin miscompares++; $display("FAIL max63_hold got %h want 63", bcd); end
   endtask

   task automatic test_blank();
      int nb; bit got;
      do_conv(6'd0, nb, got);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL zero_done got %b want 1", got); end
      vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL zero_bcd got %h want 00", bcd); end
      vectors++; if (blank !== (BLANK_ON ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL zero_blank got %b want %b", blank, BLANK_ON ? 2'b10 : 2'b00); end
      do_conv(6'd7, nb, got);
      vectors++; if (bcd !== 8'h07) begin miscompares++; $display("FAIL seven_bcd got %h want 07", bcd); end
      vectors++; if (blank !== (BLANK_ON ? 2'b10 : 2'b00)) begin miscompares++; $display("FAIL seven_blank got %b want %b", blank, BLANK_ON ? 2'b10 : 2'b00); end
      do_conv(6'd40, nb, got);
      vectors++; if (bcd !== 8'h40) begin miscompares++; $display("FAIL forty_bcd got %h want 40", bcd); end
      vectors++; if (blank !== 2'b00) begin miscompares++; $display("FAIL forty_blank got %b want 00", blank); end
   endtask

   task automatic test_wide();
      int nb; bit got;
      do_conv3(10'd999, nb, got);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL w999_done got %b want 1", got); end
      vectors++; if (nb !== 10) begin miscompares++; $display("FAIL w999_busy_cycles got %0d want 10", nb); end
      vectors++; if (bcd3 !== 12'h999) begin miscompares++; $display("FAIL w999_bcd got %h want 999", bcd3); end
      vectors++; if (overflow3 !== 1'b0) begin miscompares++; $display("FAIL w999_ovf got %b want 0", overflow3); end
      do_conv3(10'd1023, nb, got);
      vectors++; if (bcd3 !== 12'h999) begin miscompares++; $display("FAIL w1023_bcd got %h want 999", bcd3); end
      vectors++; if (overflow3 !== 1'b1) begin miscompares++; $display("FAIL w1023_ovf got %b want 1", overflow3); end
      vectors++; if (blank3 !== 3'b000) begin miscompares++; $display("FAIL w1023_blank got %b want 000", blank3); end
      do_conv3(10'd5, nb, got);
      vectors++; if (bcd3 !== 12'h005) begin miscompares++; $display("FAIL w5_bcd got %h want 005", bcd3); end
      vectors++; if (overflow3 !== 1'b0) begin miscompares++; $display("FAIL w5_ovf got %b want 0", overflow3); end
      vectors++; if (blank3 !== (BLANK_ON ? 3'b110 : 3'b000)) begin miscompares++; $display("FAIL w5_blank got %b want %b", blank3, BLANK_ON ? 3'b110 : 3'b000); end
      do_conv3(10'd60, nb, got);
      vectors++; if (bcd3 !== 12'h060) begin miscompares++; $display("FAIL w60_bcd got %h want 060", bcd3); end
      vectors++; if (blank3 !== (BLANK_ON ? 3'b100 : 3'b000)) begin miscompares++; $display("FAIL w60_blank got %b want %b", blank3, BLANK_ON ? 3'b100 : 3'b000); end
   endtask

   task automatic test_busy_mask();
      int npulse; int last_at; int gaps_bad; logic [7:0] seen;
      @(negedge clk); start = 1'b1; bin = 6'd45;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; bin = 6'd12;
      @(negedge clk); start = 1'b0;
      npulse = 0; seen = '0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin npulse++; seen = bcd; end
         @(negedge clk);
      end
      vectors++; if (npulse !== 1) begin miscompares++; $display("FAIL mask_pulses got %0d want 1", npulse); end
      vectors++; if (seen !== 8'h45) begin miscompares++; $display("FAIL mask_bcd got %h want 45", seen); end

      start = 1'b1; bin = 6'd59;
      npulse = 0; last_at = -1; gaps_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            npulse++;
            if (last_at >= 0 && (i - last_at) != 7) gaps_bad++;
            last_at = i;
            vectors++; if (bcd !== 8'h59) begin miscompares++; $display("FAIL hold_bcd got %h want 59", bcd); end
         end
         @(negedge clk);
      end
      start = 1'b0;
      vectors++; if (npulse < 5) begin miscompares++; $display("FAIL hold_pulses got %0d want >=5", npulse); end
      vectors++; if (gaps_bad !== 0) begin miscompares++; $display("FAIL hold_period got %0d bad gaps want 0", gaps_bad); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int npulse; int nb; bit got;
      @(negedge clk); start = 1'b1; bin = 6'd38;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b want 0", busy); end
      vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL rmid_bcd got %h want 00", bcd); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rmid_ovf got %b want 0", overflow); end
      npulse = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) npulse++;
         @(negedge clk);
      end
      vectors++; if (npulse !== 0) begin miscompares++; $display("FAIL rmid_done got %0d pulses want 0", npulse); end
      do_conv(6'd38, nb, got);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rmid_redo_done got %b want 1", got); end
      vectors++; if (bcd !== 8'h38) begin miscompares++; $display("FAIL rmid_redo_bcd got %h want 38", bcd); end
   endtask

   task automatic test_sweep();
      bit got; logic [7:0] exp;
      @(negedge clk); start = 1'b1; bin = 6'd0;
      for (int v = 0; v < 64; v++) begin
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
         end
         exp = {4'(v / 10), 4'(v % 10)};
         vectors++; if (got !== 1'b1 || bcd !== exp) begin miscompares++; $display("FAIL sweep_bcd v=%0d got %h (done %b) want %h", v, bcd, got, exp); end
         vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL sweep_ovf v=%0d got %b want 0", v, overflow); end
         if (v < 63) bin = 6'(v + 1);
         else start = 1'b0;
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_max63();
      test_blank();
      test_wide();
      test_busy_mask();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
